mul_share_arbiter: RTL and testbench

- Shares one pipelined signed-16 x unsigned-16 multiplier between NUM_REQ requesters in the Conv datapath (e.g. weight/feature MAC lanes).
- Round-robin arbitration with a valid/ready request handshake per requester.
- Results return on a single tagged response port, with global backpressure that stalls the whole multiplier pipeline.

---
 rtl/conv_mul_pkg.sv | 24 ++
 rtl/mul_16s_16u_pipe.sv | 91 +++++++++
 rtl/mul_share_arbiter.sv | 108 ++++++++++
 tb/tb_mul_share_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mul_pkg.sv
// Shared definitions for the Conv datapath multiplier-sharing logic:
// default operand/product widths, the requester tag type and the
// round-robin pointer advance used by the arbiter.
package conv_mul_pkg;

  localparam int A_WIDTH_DEF = 16;
  localparam int B_WIDTH_DEF = 16;
  localparam int P_WIDTH_DEF = 32;

  // Wide enough to tag up to 8 requesters.
  localparam int TAG_MAX_W = 3;

  typedef logic [TAG_MAX_W-1:0] tag_t;

  // Next round-robin pointer after granting requester idx: idx+1, wrapping
  // back to 0 past the last requester.
  function automatic tag_t rr_next(input tag_t idx, input int unsigned num_req);
    if (32'(idx) + 32'd1 >= num_req) begin
      return '0;
    end
    return idx + tag_t'(1);
  endfunction

endpackage

// File: rtl/mul_16s_16u_pipe.sv
// Pipelined signed x unsigned multiplier with a shared advance enable.
// Stage 0 registers the operands together with a valid bit and a tag;
// stages 1..LATENCY-1 carry the product. The tag and valid bit travel
// alongside so the consumer knows which requester a product belongs to.
module mul_16s_16u_pipe
  import conv_mul_pkg::*;
#(
  parameter int A_WIDTH  = A_WIDTH_DEF,
  parameter int B_WIDTH  = B_WIDTH_DEF,
  parameter int P_WIDTH  = P_WIDTH_DEF,
  parameter int LATENCY  = 3,
  parameter int ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [ID_WIDTH-1:0] in_id,
  input  logic [A_WIDTH-1:0]  in_a,
  input  logic [B_WIDTH-1:0]  in_b,
  output logic                out_valid,
  output logic [ID_WIDTH-1:0] out_id,
  output logic [P_WIDTH-1:0]  out_p,
  output logic                busy
);

  logic [LATENCY-1:0]  valid_reg;
  logic [ID_WIDTH-1:0] id_reg [LATENCY];
  logic [A_WIDTH-1:0]  a_reg;
  logic [B_WIDTH-1:0]  b_reg;

  // a is sign-extended and b zero-extended to the full product width; the
  // low P_WIDTH bits of that product are the exact signed result.
  logic signed [P_WIDTH-1:0] a_ext;
  logic signed [P_WIDTH-1:0] b_ext;
  logic [P_WIDTH-1:0]        p_comb;

  assign a_ext  = P_WIDTH'($signed(a_reg));
  assign b_ext  = $signed(P_WIDTH'(b_reg));
  assign p_comb = a_ext * b_ext;

  // Operand stage plus valid/tag shift chain; everything freezes when en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        id_reg[k] <= '0;
      end
    end else if (en) begin
      valid_reg[0] <= in_valid;
      id_reg[0]    <= in_id;
      a_reg        <= in_a;
      b_reg        <= in_b;
      for (int k = 1; k < LATENCY; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        id_reg[k]    <= id_reg[k-1];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign out_p = p_comb;
    end else begin : g_latn
      logic [P_WIDTH-1:0] p_reg [LATENCY-1];

      // Product register chain feeding the output stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < LATENCY - 1; k++) begin
            p_reg[k] <= '0;
          end
        end else if (en) begin
          p_reg[0] <= p_comb;
          for (int k = 1; k < LATENCY - 1; k++) begin
            p_reg[k] <= p_reg[k-1];
          end
        end
      end

      assign out_p = p_reg[LATENCY-2];
    end
  endgenerate

  assign out_valid = valid_reg[LATENCY-1];
  assign out_id    = id_reg[LATENCY-1];
  assign busy      = |valid_reg;

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined multiplier between NUM_REQ requesters. A
// round-robin arbiter accepts at most one request per cycle; products
// come back in grant order on a single tagged response port. A stalled
// response (valid without ready) freezes the whole pipeline and blocks
// all new grants.
module mul_share_arbiter
  import conv_mul_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int A_WIDTH     = A_WIDTH_DEF,
  parameter int B_WIDTH     = B_WIDTH_DEF,
  parameter int P_WIDTH     = P_WIDTH_DEF,
  parameter int MUL_LATENCY = 3,
  parameter int ID_WIDTH    = 2
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       busy
);

  logic [ID_WIDTH-1:0] ptr_reg;
  logic [ID_WIDTH-1:0] ptr_next;
  logic                stall;
  logic                transfer;
  logic                grant_found;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH:0]   idx_sum;
  logic [A_WIDTH-1:0]  a_slice [NUM_REQ];
  logic [B_WIDTH-1:0]  b_slice [NUM_REQ];
  logic [A_WIDTH-1:0]  sel_a;
  logic [B_WIDTH-1:0]  sel_b;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign a_slice[gi] = req_a[gi*A_WIDTH +: A_WIDTH];
      assign b_slice[gi] = req_b[gi*B_WIDTH +: B_WIDTH];
    end
  endgenerate

  assign stall = rsp_valid & ~rsp_ready;

  // Round-robin search starting at ptr_reg; first valid requester wins.
  always_comb begin
    grant_oh    = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    idx_sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = {1'b0, ptr_reg} + (ID_WIDTH+1)'(k);
      if (idx_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
        idx_sum = idx_sum - (ID_WIDTH+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[idx_sum[ID_WIDTH-1:0]]) begin
        grant_found                     = 1'b1;
        grant_id                        = idx_sum[ID_WIDTH-1:0];
        grant_oh[idx_sum[ID_WIDTH-1:0]] = 1'b1;
      end
    end
  end

  // Ready is suppressed while stalled and while reset is held, so nothing
  // is offered to a requester that cannot actually be accepted.
  assign req_ready = grant_oh & {NUM_REQ{~stall & ap_rst_n}};
  assign transfer  = grant_found & ~stall;
  assign sel_a     = a_slice[grant_id];
  assign sel_b     = b_slice[grant_id];
  assign ptr_next  = transfer ? ID_WIDTH'(rr_next(tag_t'(grant_id), NUM_REQ)) : ptr_reg;

  // Round-robin pointer: moves just past the requester granted this cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  mul_16s_16u_pipe #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .P_WIDTH  (P_WIDTH),
    .LATENCY  (MUL_LATENCY),
    .ID_WIDTH (ID_WIDTH)
  ) u_mul (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .en        (~stall),
    .in_valid  (transfer),
    .in_id     (grant_id),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_p     (rsp_p),
    .busy      (busy)
  );

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: accepted requests push their
// expected tagged product, responses pop and compare in order.
module tb_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 16;
  localparam int BW      = 16;
  localparam int PW      = 32;
  localparam int LAT     = 3;
  localparam int IW      = 2;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_a;
  logic [NUM_REQ*BW-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [PW-1:0]         rsp_p;
  logic                  busy;

  always #5 ap_clk = ~ap_clk;

  mul_share_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .A_WIDTH     (AW),
    .B_WIDTH     (BW),
    .P_WIDTH     (PW),
    .MUL_LATENCY (LAT),
    .ID_WIDTH    (IW)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  typedef struct {
    int id;
    int p;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   rsp_cyc_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_lat = 0;
  int last_p [NUM_REQ];

  logic [NUM_REQ-1:0] acc_flag = '0;
  logic signed [AW-1:0] op_a [NUM_REQ];
  logic [BW-1:0]        op_b [NUM_REQ];
  int                   pend [NUM_REQ];

  exp_t e_mon;
  int   ea_mon;
  int   eb_mon;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Monitor: record accepted requests with their expected product, and
  // compare every delivered response against the head of the scoreboard.
  always @(negedge ap_clk) begin
    acc_flag = req_valid & req_ready;
    if (|req_ready) check_val("ready_onehot", $countones(req_ready), 1);
    if (rsp_valid && !rsp_ready) check_val("ready_in_stall", {28'b0, req_ready}, 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        ea_mon   = int'($signed(req_a[i*AW +: AW]));
        eb_mon   = int'(req_b[i*BW +: BW]);
        e_mon.id  = i;
        e_mon.p   = ea_mon * eb_mon;
        e_mon.cyc = cyc;
        exp_q.push_back(e_mon);
        grant_q.push_back(i);
        $display("t=%0t req id=%0d a=%0d b=%0d", $time, i, ea_mon, eb_mon);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_val("rsp_unexpected", {31'b0, rsp_valid}, 0);
      end else begin
        e_mon = exp_q.pop_front();
        check_val("rsp_id", {30'b0, rsp_id}, e_mon.id);
        check_val("rsp_p", rsp_p, e_mon.p);
        last_lat     = cyc - e_mon.cyc;
        last_p[e_mon.id] = int'(rsp_p);
        rsp_cyc_q.push_back(cyc);
        $display("t=%0t rsp id=%0d p=%0d", $time, rsp_id, $signed(rsp_p));
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]           = (pend[i] > 0);
      req_a[i*AW +: AW]      = op_a[i];
      req_b[i*BW +: BW]      = op_b[i];
    end
  endtask

  // One clock: retire requests accepted on the edge just passed (fresh
  // operands for the next one), then drive the new request set.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_flag[i]) begin
        pend[i]--;
        op_a[i] = AW'($urandom);
        op_b[i] = BW'($urandom);
      end
    end
    acc_flag = '0;
    drive();
  endtask

  function automatic int pend_total();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += pend[i];
    return s;
  endfunction

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((pend_total() > 0 || exp_q.size() > 0) && n < max_cyc) begin
      tick();
      n++;
    end
    if (n >= max_cyc) check_val("drain_timeout", pend_total() + exp_q.size(), 0);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = AW'($urandom);
      op_b[i] = BW'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [IW-1:0] id_hold;
    logic [PW-1:0] p_hold;

    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i]   = 0;
      op_a[i]   = '0;
      op_b[i]   = '0;
      last_p[i] = 0;
    end
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state, with all requesters valid to exercise ready gating.
    repeat (2) @(posedge ap_clk);
    #1;
    check_val("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check_val("rst_rsp_id", {30'b0, rsp_id}, 0);
    check_val("rst_rsp_p", rsp_p, 0);
    check_val("rst_busy", {31'b0, busy}, 0);
    check_val("rst_req_ready", {28'b0, req_ready}, 0);
    req_valid = '0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single request: -3 * 7 from requester 0.
    op_a[0] = -16'sd3;
    op_b[0] = 16'd7;
    pend[0] = 1;
    tick();
    #1;
    check_val("single_ready", {28'b0, req_ready}, 32'b0001);
    tick();
    check_val("single_busy", {31'b0, busy}, 1);
    drain(20);
    check_val("single_lat", last_lat, LAT);
    check_val("single_p", last_p[0], 32'hFFFF_FFEB);  // -21
    check_val("single_busy_fall", {31'b0, busy}, 0);

    // Operand extremes on requesters 2 and 3 (pointer is 1 here).
    grant_q.delete();
    op_a[2] = 16'sh8000;  op_b[2] = 16'hFFFF;
    op_a[3] = 16'sh7FFF;  op_b[3] = 16'hFFFF;
    pend[2] = 1;
    pend[3] = 1;
    tick();
    drain(20);
    check_val("ext_min_p", last_p[2], 32'h8000_8000);  // -2147450880
    check_val("ext_max_p", last_p[3], 32'h7FFE_8001);  // 2147385345
    check_val("ext_n_grants", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      check_val("ext_grant0", grant_q[0], 2);
      check_val("ext_grant1", grant_q[1], 3);
    end

    // Round-robin fairness: all four valid for 8 grants.
    grant_q.delete();
    rsp_cyc_q.delete();
    rand_ops();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 2;
    tick();
    drain(40);
    check_val("rr_n_grants", grant_q.size(), 8);
    if (grant_q.size() == 8) begin
      for (int k = 0; k < 8; k++) check_val("rr_grant", grant_q[k], k % 4);
    end
    check_val("rr_n_rsp", rsp_cyc_q.size(), 8);
    if (rsp_cyc_q.size() == 8) check_val("rr_rsp_span", rsp_cyc_q[7] - rsp_cyc_q[0], 7);

    // Backpressure: three in flight with the consumer stalled.
    rsp_cyc_q.delete();
    rsp_ready = 1'b0;
    rand_ops();
    for (int i = 0; i < 3; i++) pend[i] = 1;
    n = 0;
    tick();
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    check_val("bp_rsp_valid", {31'b0, rsp_valid}, 1);
    check_val("bp_first_id", {30'b0, rsp_id}, 0);
    id_hold = rsp_id;
    p_hold  = rsp_p;
    pend[3] = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check_val("bp_hold_valid", {31'b0, rsp_valid}, 1);
      check_val("bp_hold_id", {30'b0, rsp_id}, {30'b0, id_hold});
      check_val("bp_hold_p", rsp_p, p_hold);
      check_val("bp_ready_zero", {28'b0, req_ready}, 0);
    end
    rsp_ready = 1'b1;
    drain(20);
    check_val("bp_n_rsp", rsp_cyc_q.size(), 4);
    if (rsp_cyc_q.size() == 4) begin
      check_val("bp_gap01", rsp_cyc_q[1] - rsp_cyc_q[0], 1);
      check_val("bp_gap12", rsp_cyc_q[2] - rsp_cyc_q[1], 1);
    end

    // Pointer skip: move pointer to 1, then requesters 3 and 0 compete.
    grant_q.delete();
    pend[0] = 1;
    tick();
    drain(20);
    check_val("skip_setup", grant_q.size() > 0 ? grant_q[0] : -1, 0);
    grant_q.delete();
    pend[0] = 1;
    pend[3] = 2;
    tick();
    drain(20);
    check_val("skip_n_grants", grant_q.size(), 3);
    if (grant_q.size() == 3) begin
      check_val("skip_grant0", grant_q[0], 3);
      check_val("skip_grant1", grant_q[1], 0);
      check_val("skip_grant2", grant_q[2], 3);
    end

    // Reset mid-flight with two entries in the pipeline.
    grant_q.delete();
    rand_ops();
    pend[0] = 1;
    pend[1] = 1;
    n = 0;
    while (grant_q.size() < 2 && n < 10) begin
      tick();
      n++;
    end
    check_val("mid_busy_before", {31'b0, busy}, 1);
    ap_rst_n = 1'b0;
    #1;
    check_val("mid_rsp_valid", {31'b0, rsp_valid}, 0);
    check_val("mid_busy", {31'b0, busy}, 0);
    check_val("mid_rsp_id", {30'b0, rsp_id}, 0);
    check_val("mid_rsp_p", rsp_p, 0);
    req_valid = '1;
    #1;
    check_val("mid_req_ready", {28'b0, req_ready}, 0);
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
    exp_q.delete();
    repeat (2) @(posedge ap_clk);
    req_valid = '0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("mid_no_stale", {31'b0, rsp_valid}, 0);
    end
    grant_q.delete();
    rand_ops();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1;
    tick();
    drain(30);
    check_val("mid_first_grant", grant_q.size() > 0 ? grant_q[0] : -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
